if_fetch_unit: RTL and testbench

//  IF-stage producer for the 5-stage MIPS pipeline: owns the PC, issues in-order word reads to

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_fetch_unit_fetch_fifo.sv | 67 ++++++
 rtl/if_fetch_unit.sv | 107 ++++++++++
 tb/tb_if_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch-buffer entry layout and PC helpers used by the top and its FIFO.
package if_fetch_unit_pkg;

    localparam int          WORD_W       = 32;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] npc;
        logic [WORD_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of {npc, inst} entries with flush, full/empty and occupancy.
// Head is read combinationally from registered storage, so a push is visible the next cycle.
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output fetch_entry_t       head_data,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        count     = count_q;
        head_data = mem_q[rd_ptr_q];
        pop_ok    = pop && !empty;
        // A push into a full FIFO is legal only when the head leaves in the same cycle.
        push_ok   = push && (!full || pop_ok);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, issues in-order word reads to instruction memory and
// presents buffered instructions to IF/ID, honouring stall and branch redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INST  = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] npc_IF,
    output logic [31:0] inst_IF,
    output logic        valid_IF
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(BUF_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] live_q, live_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    fetch_entry_t     head, push_entry;
    logic [SUM_W-1:0] credit_sum;
    logic             issue, rsp_drop, rsp_take, push, pop;

    // Handshakes: a request issues on a cycle where imem_req && imem_gnt; responses
    // return in issue order as single-cycle imem_rvalid pulses with no back-pressure;
    // IF/ID consumes the head on a cycle where valid_IF && !stall && !redirect.
    always_comb begin
        credit_sum = SUM_W'(fifo_count) + SUM_W'(live_q) + SUM_W'(drop_q);
        imem_req   = !rst && !redirect && (credit_sum < DEPTH_S);
        imem_addr  = pc_q;
        issue      = imem_req && imem_gnt;

        rsp_drop   = imem_rvalid && (drop_q != '0);
        rsp_take   = imem_rvalid && (drop_q == '0) && (live_q != '0);

        // Live requests are consecutive words ending just below pc_q, so the oldest
        // one sits live_q words back; its npc is one word past that.
        push_entry.npc  = pc_q - (32'(live_q) << 2) + PC_INC;
        push_entry.inst = imem_rdata;

        pop  = !fifo_empty && !stall && !redirect;
        push = rsp_take && !redirect && (!fifo_full || pop);

        pc_d   = pc_q;
        live_d = live_q;
        drop_d = drop_q;
        if (rsp_drop) drop_d = drop_q - CNT_W'(1);
        if (rsp_take) live_d = live_q - CNT_W'(1);
        if (redirect) begin
            pc_d   = align_word(redirect_pc);
            drop_d = drop_d + live_d;
            live_d = '0;
        end else if (issue) begin
            pc_d   = pc_q + PC_INC;
            live_d = live_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            live_q <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            live_q <= live_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        valid_IF = !fifo_empty;
        inst_IF  = fifo_empty ? NOP_INST : head.inst;
        npc_IF   = fifo_empty ? 32'h0    : head.npc;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a queue-based model of the fetch stage plus a
// simple in-order memory, compared against the DUT every cycle away from the clock edge.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam int          D        = 2;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, valid_IF;
    logic [31:0] imem_addr, npc_IF, inst_IF;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (D),
        .NOP_INST  (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .npc_IF      (npc_IF),
        .inst_IF     (inst_IF),
        .valid_IF    (valid_IF)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: presented instructions, in-flight request PCs, stale responses to drop.
    logic [63:0] exp_q[$];
    logic [31:0] req_q[$];
    logic [31:0] m_pc;
    int          m_drop;

    // Memory environment: granted addresses and the cycle each was granted.
    logic [31:0] mem_addr_q[$];
    int          mem_cyc_q[$];
    logic        rv_en;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_npc, s_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle(input logic i_rst, input logic i_stall, input logic i_redir,
                         input logic [31:0] i_rpc, input logic i_gnt, input logic i_spur);
        logic        rv, rv_mem, e_req, e_valid, have;
        logic [31:0] rd, e_npc, e_inst;
        logic [63:0] resp;
        @(negedge clk);
        rst         = i_rst;
        stall       = i_stall;
        redirect    = i_redir;
        redirect_pc = i_rpc;
        imem_gnt    = i_gnt;
        rv = 1'b0; rv_mem = 1'b0; rd = 32'hDEAD_BEEF;
        if (!i_rst && rv_en && mem_addr_q.size() > 0 && mem_cyc_q[0] < cyc) begin
            rv = 1'b1; rv_mem = 1'b1; rd = inst_of(mem_addr_q[0]);
        end else if (i_spur) begin
            rv = 1'b1; rd = 32'hBAD0_0001;
        end
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;

        e_req   = !i_rst && !i_redir && (exp_q.size() + req_q.size() + m_drop < D);
        e_valid = exp_q.size() > 0;
        e_npc   = 32'h0;
        e_inst  = NOP;
        if (e_valid) begin
            e_npc  = exp_q[0][63:32];
            e_inst = exp_q[0][31:0];
        end
        check("imem_req", imem_req, e_req);
        if (e_req) check("imem_addr", imem_addr, m_pc);
        check("valid_IF", valid_IF, e_valid);
        check("npc_IF", npc_IF, e_npc);
        check("inst_IF", inst_IF, e_inst);
        s_req = imem_req; s_addr = imem_addr; s_valid = valid_IF; s_npc = npc_IF; s_inst = inst_IF;

        if (rv_mem) begin
            void'(mem_addr_q.pop_front());
            void'(mem_cyc_q.pop_front());
        end
        if (imem_req && i_gnt && !i_rst) begin
            mem_addr_q.push_back(imem_addr);
            mem_cyc_q.push_back(cyc);
        end
        if (i_rst) begin
            mem_addr_q.delete();
            mem_cyc_q.delete();
        end

        if (i_rst) begin
            m_pc = RESET_PC; m_drop = 0;
            exp_q.delete(); req_q.delete();
        end else begin
            have = 1'b0;
            resp = '0;
            if (rv) begin
                if (m_drop > 0) m_drop--;
                else if (req_q.size() > 0) begin
                    resp = {req_q[0] + 32'd4, rd};
                    void'(req_q.pop_front());
                    have = 1'b1;
                end
            end
            if (i_redir) begin
                exp_q.delete();
                m_drop += req_q.size();
                req_q.delete();
                m_pc = i_rpc & ~32'h3;
            end else begin
                if (e_valid && !i_stall) void'(exp_q.pop_front());
                if (have) exp_q.push_back(resp);
                if (e_req && i_gnt) begin
                    req_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input logic i_stall, input logic i_gnt);
        for (int i = 0; i < n; i++) cycle(1'b0, i_stall, 1'b0, 32'h0, i_gnt, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; rv_en = 1'b1;
        m_pc = RESET_PC; m_drop = 0;
        repeat (2) @(posedge clk);

        // Reset then straight-line fetch.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("req_in_rst", s_req, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("first_req", s_req, 1'b1);
        check("first_addr", s_addr, 32'h0040_0000);
        run(2, 1'b0, 1'b1);
        check("first_valid", s_valid, 1'b1);
        check("first_npc", s_npc, 32'h0040_0004);
        check("first_inst", s_inst, inst_of(32'h0040_0000));
        run(8, 1'b0, 1'b1);

        // Stall holds the head and lets credits run out.
        run(5, 1'b1, 1'b1);
        check("stall_req_off", s_req, 1'b0);
        run(6, 1'b0, 1'b1);

        // Redirect with two requests in flight.
        rv_en = 1'b0;
        run(5, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0103, 1'b1, 1'b0);
        check("model_drop2", m_drop, 2);
        rv_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 12) check("redir_timeout", 32'd0, 32'd1);
            else begin
                cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
                if (s_req && !seen) begin
                    check("redir_addr", s_addr, 32'h0040_0100);
                    seen = 1'b1;
                end
                if (s_valid) begin
                    check("redir_npc", s_npc, 32'h0040_0104);
                    check("redir_inst", s_inst, inst_of(32'h0040_0100));
                    break;
                end
            end
        end

        // Redirect and stall together; then back-to-back redirects.
        run(2, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'h0040_0200, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("redir_stall_flush", s_valid, 1'b0);
        run(2, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0300, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0404, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) begin
            if (i == 12) check("b2b_timeout", 32'd0, 32'd1);
            else begin
                cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
                if (s_valid) begin
                    check("b2b_npc", s_npc, 32'h0040_0408);
                    break;
                end
            end
        end

        // Grant withheld: request held, buffer drains.
        run(6, 1'b0, 1'b0);
        check("nogrant_req", s_req, 1'b1);
        check("nogrant_drained", s_valid, 1'b0);
        run(4, 1'b0, 1'b1);

        // Reset with a full buffer, then a spurious response.
        run(4, 1'b1, 1'b1);
        check("model_full", exp_q.size(), D);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("rst_valid", s_valid, 1'b0);
        check("rst_req", s_req, 1'b1);
        check("rst_addr", s_addr, RESET_PC);
        run(8, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
